// File: rtl/ucy_pkg.sv
// Shared types and helpers for the ucy_7490 decade counter model.
// Holds the BCD type, the reset/preset BCD constants and the ÷5
// successor function. The successor covers the illegal states too,
// because an R9 preset followed by a poke can land the ÷5 section
// outside its normal 000..100 cycle.
package ucy_pkg;

   typedef logic [3:0] ucy_bcd_t;

   localparam ucy_bcd_t UCY_BCD_ZERO = 4'h0;
   localparam ucy_bcd_t UCY_BCD_NINE = 4'h9;

   // Successor of the ÷5 section {QD,QC,QB}. The illegal states advance
   // the same way the original part does.
   function automatic logic [2:0] ucy_div5_next(input logic [2:0] cur);
      logic [2:0] nxt;
      case (cur)
         3'b000:  nxt = 3'b001;
         3'b001:  nxt = 3'b010;
         3'b010:  nxt = 3'b011;
         3'b011:  nxt = 3'b100;
         3'b100:  nxt = 3'b000;
         3'b101:  nxt = 3'b010;
         3'b110:  nxt = 3'b010;
         3'b111:  nxt = 3'b000;
         default: nxt = 3'b000;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/ucy_pin_cond.sv
// Per-pin conditioning for ucy_7490: sampling (plus a two-flop
// synchroniser when UCY_INPUT_SYNC_EN is defined), an optional glitch
// filter of FILTER_LEN cycles, and falling-edge detection on the
// filtered level. With the macro undefined the pin must already be
// synchronous to clk.
module ucy_pin_cond #(
   parameter int FILTER_LEN = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic level,
   output logic fall
);

   logic samp_q;
   logic level_s;
   logic prev_q;

`ifdef UCY_INPUT_SYNC_EN
   logic meta_q;
   logic sync_q;

   // Two-flop synchroniser ahead of the sampling register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         samp_q <= 1'b0;
      end else begin
         meta_q <= pin;
         sync_q <= meta_q;
         samp_q <= sync_q;
      end
   end
`else
   // Single sampling register; the pin is already synchronous to clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_q <= 1'b0;
      end else begin
         samp_q <= pin;
      end
   end
`endif

   generate
      if (FILTER_LEN == 0) begin : g_nofilt
         assign level_s = samp_q;
      end else begin : g_filt
         localparam int CW = $clog2(FILTER_LEN + 1);
         localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

         logic          filt_q;
         logic          filt_d;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // Accept a new level only after it has differed for FILTER_LEN cycles.
         always_comb begin
            filt_d = filt_q;
            cnt_d  = cnt_q;
            if (samp_q == filt_q) begin
               cnt_d = {CW{1'b0}};
            end else if (cnt_q >= LAST) begin
               filt_d = samp_q;
               cnt_d  = {CW{1'b0}};
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // Filter state registers.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               filt_q <= 1'b0;
               cnt_q  <= {CW{1'b0}};
            end else begin
               filt_q <= filt_d;
               cnt_q  <= cnt_d;
            end
         end

         assign level_s = filt_q;
      end
   endgenerate

   // Edge history; cleared to 0 so a first sampled 1 is a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= level_s;
      end
   end

   assign level = level_s;
   assign fall  = prev_q & ~level_s;

endmodule

// File: rtl/ucy_7490.sv
// Pin-accurate 7490 decade counter (÷2 + ÷5) clocked from one system clock.
// CKA/CKB are sampled pins edge-detected on clk; no derived clocks.
// Optional build macro: UCY_INPUT_SYNC_EN adds a two-flop synchroniser
// on every input pin (+2 cycles latency).
// Bit order of the internal state is {QD,QC,QB,QA}.
module ucy_7490
   import ucy_pkg::*;
#(
   parameter int FILTER_LEN = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic p1,
   input  logic p2,
   input  logic p3,
   input  logic p4,
   input  logic p5,
   input  logic p6,
   input  logic p7,
   output logic p8,
   output logic p9,
   input  logic p10,
   output logic p11,
   output logic p12,
   input  logic p13,
   input  logic p14
);

   logic cka_level_s, cka_fall_s;
   logic ckb_level_s, ckb_fall_s;
   logic r01_level_s, r01_fall_s;
   logic r02_level_s, r02_fall_s;
   logic r91_level_s, r91_fall_s;
   logic r92_level_s, r92_fall_s;
   logic r0_s;
   logic r9_s;
   logic unused_s;

   ucy_bcd_t bcd_q;
   ucy_bcd_t bcd_d;

   ucy_pin_cond #(.FILTER_LEN(FILTER_LEN)) u_cka (.clk(clk), .rst(rst), .pin(p14), .level(cka_level_s), .fall(cka_fall_s));
   ucy_pin_cond #(.FILTER_LEN(FILTER_LEN)) u_ckb (.clk(clk), .rst(rst), .pin(p1),  .level(ckb_level_s), .fall(ckb_fall_s));
   ucy_pin_cond #(.FILTER_LEN(FILTER_LEN)) u_r01 (.clk(clk), .rst(rst), .pin(p2),  .level(r01_level_s), .fall(r01_fall_s));
   ucy_pin_cond #(.FILTER_LEN(FILTER_LEN)) u_r02 (.clk(clk), .rst(rst), .pin(p3),  .level(r02_level_s), .fall(r02_fall_s));
   ucy_pin_cond #(.FILTER_LEN(FILTER_LEN)) u_r91 (.clk(clk), .rst(rst), .pin(p6),  .level(r91_level_s), .fall(r91_fall_s));
   ucy_pin_cond #(.FILTER_LEN(FILTER_LEN)) u_r92 (.clk(clk), .rst(rst), .pin(p7),  .level(r92_level_s), .fall(r92_fall_s));

   assign r9_s = r91_level_s & r92_level_s;
   assign r0_s = r01_level_s & r02_level_s;

   // Power/NC pins and unneeded conditioner outputs are intentionally dropped.
   assign unused_s = ^{p4, p5, p10, p13, cka_level_s, ckb_level_s,
                       r01_fall_s, r02_fall_s, r91_fall_s, r92_fall_s};

   // Priority R9 > R0 > count; clock edges under R0/R9 are discarded.
   always_comb begin
      bcd_d = bcd_q;
      if (r9_s) begin
         bcd_d = UCY_BCD_NINE;
      end else if (r0_s) begin
         bcd_d = UCY_BCD_ZERO;
      end else begin
         if (cka_fall_s) begin
            bcd_d[0] = ~bcd_q[0];
         end else begin
            bcd_d[0] = bcd_q[0];
         end
         if (ckb_fall_s) begin
            bcd_d[3:1] = ucy_div5_next(bcd_q[3:1]);
         end else begin
            bcd_d[3:1] = bcd_q[3:1];
         end
      end
   end

   // Counter state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_q <= UCY_BCD_ZERO;
      end else begin
         bcd_q <= bcd_d;
      end
   end

   assign p12 = bcd_q[0];
   assign p9  = bcd_q[1];
   assign p8  = bcd_q[2];
   assign p11 = bcd_q[3];

endmodule

// File: tb/tb_ucy_7490.sv
// Self-checking bench for ucy_7490: dut0 unfiltered, dut1 with FILTER_LEN = 3.
module tb_ucy_7490;
   import ucy_pkg::*;

`ifdef UCY_INPUT_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic p1, p1_drv, bcd_mode;
   logic p2, p3, p6, p7, p14;
   logic p8, p9, p11, p12;
   logic p14f;
   logic f_p8, f_p9, f_p11, f_p12;

   int n_run  = 0;
   int n_fail = 0;

   ucy_bcd_t exp_q[$];
   ucy_bcd_t exp_v;
   ucy_bcd_t got_v;

   assign p1 = bcd_mode ? p12 : p1_drv;

   ucy_7490 #(.FILTER_LEN(0)) dut0 (
      .clk(clk), .rst(rst), .p1(p1), .p2(p2), .p3(p3), .p4(1'b0), .p5(1'b1),
      .p6(p6), .p7(p7), .p8(p8), .p9(p9), .p10(1'b0), .p11(p11), .p12(p12),
      .p13(1'b0), .p14(p14)
   );

   ucy_7490 #(.FILTER_LEN(3)) dut1 (
      .clk(clk), .rst(rst), .p1(1'b0), .p2(1'b0), .p3(1'b0), .p4(1'b0), .p5(1'b1),
      .p6(1'b0), .p7(1'b0), .p8(f_p8), .p9(f_p9), .p10(1'b0), .p11(f_p11), .p12(f_p12),
      .p13(1'b0), .p14(p14f)
   );

   function automatic ucy_bcd_t obs0();
      return {p11, p8, p9, p12};
   endfunction

   function automatic ucy_bcd_t obs1();
      return {f_p11, f_p8, f_p9, f_p12};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      p1_drv = 1'b0; bcd_mode = 1'b0;
      p2 = 1'b0; p3 = 1'b0; p6 = 1'b0; p7 = 1'b0;
      p14 = 1'b0; p14f = 1'b0;
      step(2);
      rst = 1'b0;
      step(2);
   endtask

   task automatic pulse_cka();
      p14 = 1'b1;
      step(2 + S);
      p14 = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_run++;
      if (obs0() !== 4'h0) begin
         n_fail++; $display("FAIL reset_dut0: got %b expected 0000", obs0());
      end
      n_run++;
      if (obs1() !== 4'h0) begin
         n_fail++; $display("FAIL reset_dut1: got %b expected 0000", obs1());
      end
      pulse_cka();
      exp_q.push_back(4'h1);
      step(2 + S);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs0() !== exp_v) begin
         n_fail++; $display("FAIL reset_precount: got %b expected %b", obs0(), exp_v);
      end
      // async assertion between clock edges
      #2 rst = 1'b1;
      #1;
      n_run++;
      if (obs0() !== 4'h0) begin
         n_fail++; $display("FAIL reset_async: got %b expected 0000", obs0());
      end
      p14 = 1'b1;
      step(2);
      rst = 1'b0;
      step(4 + S);
      n_run++;
      if (obs0() !== 4'h0) begin
         n_fail++; $display("FAIL reset_release_cka_high: got %b expected 0000", obs0());
      end
      p14 = 1'b0;
      exp_q.push_back(4'h1);
      step(2 + S);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs0() !== exp_v) begin
         n_fail++; $display("FAIL reset_first_fall: got %b expected %b", obs0(), exp_v);
      end
   endtask

   task automatic test_div2();
      logic pre_v;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         pre_v = (i % 2 == 0) ? 1'b0 : 1'b1;
         pulse_cka();
         exp_q.push_back((i % 2 == 0) ? 4'h1 : 4'h0);
         step(1 + S);
         got_v = obs0();
         n_run++;
         if (got_v[0] !== pre_v) begin
            n_fail++; $display("FAIL div2_early[%0d]: got QA=%b expected %b", i, got_v[0], pre_v);
         end
         step(1);
         exp_v = exp_q.pop_front();
         n_run++;
         if (obs0() !== exp_v) begin
            n_fail++; $display("FAIL div2[%0d]: got %b expected %b", i, obs0(), exp_v);
         end
      end
   endtask

   task automatic test_bcd();
      do_reset();
      bcd_mode = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         p14 = 1'b1;
         step(3 + S);
         p14 = 1'b0;
         exp_q.push_back(ucy_bcd_t'(i % 10));
         step(6 + 2 * S);
         exp_v = exp_q.pop_front();
         n_run++;
         if (obs0() !== exp_v) begin
            n_fail++; $display("FAIL bcd[%0d]: got %b expected %b", i, obs0(), exp_v);
         end
      end
      bcd_mode = 1'b0;
   endtask

   task automatic test_r9_priority();
      do_reset();
      p2 = 1'b1; p3 = 1'b1; p6 = 1'b1; p7 = 1'b1;
      exp_q.push_back(4'h9);
      step(2 + S);
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin
            pulse_cka();
            step(2 + S);
            exp_q.push_back(4'h9);
         end
         exp_v = exp_q.pop_front();
         n_run++;
         if (obs0() !== exp_v) begin
            n_fail++; $display("FAIL r9_hold[%0d]: got %b expected %b", k, obs0(), exp_v);
         end
      end
      p7 = 1'b0;
      exp_q.push_back(4'h0);
      step(2 + S);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs0() !== exp_v) begin
         n_fail++; $display("FAIL r0_after_r9: got %b expected %b", obs0(), exp_v);
      end
      pulse_cka();
      exp_q.push_back(4'h0);
      step(2 + S);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs0() !== exp_v) begin
         n_fail++; $display("FAIL r0_discard: got %b expected %b", obs0(), exp_v);
      end
      p2 = 1'b0;
      step(2 + S);
      pulse_cka();
      exp_q.push_back(4'h1);
      step(2 + S);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs0() !== exp_v) begin
         n_fail++; $display("FAIL resume_cka: got %b expected %b", obs0(), exp_v);
      end
      p1_drv = 1'b1;
      step(2 + S);
      p1_drv = 1'b0;
      exp_q.push_back(4'h3);
      step(2 + S);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs0() !== exp_v) begin
         n_fail++; $display("FAIL resume_ckb: got %b expected %b", obs0(), exp_v);
      end
   endtask

   task automatic test_illegal();
      logic [2:0] tbl [8];
      logic [2:0] st;
      tbl = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b010, 3'b010, 3'b000};
      for (int s = 0; s < 8; s++) begin
         st = 3'(s);
         n_run++;
         if (ucy_div5_next(st) !== tbl[s]) begin
            n_fail++; $display("FAIL div5_fn[%0d]: got %b expected %b", s, ucy_div5_next(st), tbl[s]);
         end
      end
      do_reset();
      force dut0.bcd_q = 4'b1100;
      step(1);
      release dut0.bcd_q;
      step(1);
      n_run++;
      if (obs0() !== 4'b1100) begin
         n_fail++; $display("FAIL illegal_poke: got %b expected 1100", obs0());
      end
      p1_drv = 1'b1;
      step(2 + S);
      p1_drv = 1'b0;
      exp_q.push_back(4'b0100);
      step(2 + S);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs0() !== exp_v) begin
         n_fail++; $display("FAIL illegal_110_step: got %b expected %b", obs0(), exp_v);
      end
   endtask

   task automatic test_filter();
      do_reset();
      p14f = 1'b1;
      step(8 + S);
      n_run++;
      if (f_p12 !== 1'b0) begin
         n_fail++; $display("FAIL filt_rise: got QA=%b expected 0", f_p12);
      end
      p14f = 1'b0;
      step(2);
      p14f = 1'b1;
      step(10 + S);
      n_run++;
      if (f_p12 !== 1'b0) begin
         n_fail++; $display("FAIL filt_glitch2: got QA=%b expected 0", f_p12);
      end
      p14f = 1'b0;
      step(3);
      p14f = 1'b1;
      exp_q.push_back(4'h1);
      step(1 + S);
      n_run++;
      if (f_p12 !== 1'b0) begin
         n_fail++; $display("FAIL filt_low3_early: got QA=%b expected 0", f_p12);
      end
      step(1);
      exp_v = exp_q.pop_front();
      n_run++;
      if (obs1() !== exp_v) begin
         n_fail++; $display("FAIL filt_low3: got %b expected %b", obs1(), exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_div2();
      test_bcd();
      test_r9_priority();
      test_illegal();
      test_filter();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
